microprocesador: RTL and testbench

Single-cycle 8-bit accumulator microprocessor with a 9-bit instruction word and Harvard-style external memories. It fetches from an external instruction ROM addressed by its program counter and reads or writes an external data RAM through a separate address/data/RW port. It is the CPU core of the system and contains no memories of its own.

---
 rtl/microprocesador.sv | 84 ++++++++
 tb/tb_microprocesador.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/microprocesador.sv
// Single-cycle 8-bit accumulator CPU with a 9-bit instruction word.
// Instruction ROM and data RAM are external; this block holds only PC, A, Z and C.
module microprocesador (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] Datos_Entrada,
  input  logic [8:0] Instrucciones,
  output logic [7:0] Direccion_Instrucciones,
  output logic [7:0] Direccion_Datos,
  output logic [7:0] Salida_Datos,
  output logic       RW
);

  localparam logic [2:0] OP_LDI = 3'b000;
  localparam logic [2:0] OP_LD  = 3'b001;
  localparam logic [2:0] OP_ST  = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_JMP = 3'b110;
  localparam logic [2:0] OP_JZ  = 3'b111;

  logic [2:0] opcode;
  logic [7:0] field;

  logic [7:0] pc_q, pc_d;
  logic [7:0] a_q, a_d;
  logic       z_q, z_d;
  logic       c_q, c_d;
  logic       z_upd;

  assign opcode = Instrucciones[8:6];
  assign field  = {2'b00, Instrucciones[5:0]};

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    pc_d  = pc_q + 8'd1;
    a_d   = a_q;
    z_d   = z_q;
    c_d   = c_q;
    z_upd = 1'b0;
    unique case (opcode)
      OP_LDI: begin a_d = field;               z_upd = 1'b1; end
      OP_LD:  begin a_d = Datos_Entrada;       z_upd = 1'b1; end
      OP_ST:  ;
      OP_ADD: begin
        {c_d, a_d} = {1'b0, a_q} + {1'b0, Datos_Entrada};
        z_upd      = 1'b1;
      end
      OP_SUB: begin
        a_d   = a_q - Datos_Entrada;
        c_d   = (a_q < Datos_Entrada);
        z_upd = 1'b1;
      end
      OP_AND: begin a_d = a_q & Datos_Entrada; z_upd = 1'b1; end
      OP_JMP: pc_d = field;
      OP_JZ:  if (z_q) pc_d = field;
      default: ;
    endcase
    if (z_upd) z_d = (a_d == 8'h00);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pc_q <= 8'h00;
      a_q  <= 8'h00;
      z_q  <= 1'b0;
      c_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all state updates see the pre-edge values.
      pc_q <= pc_d;
      a_q  <= a_d;
      z_q  <= z_d;
      c_q  <= c_d;
    end
  end

  assign Direccion_Instrucciones = pc_q;
  assign Direccion_Datos         = field;
  assign Salida_Datos            = a_q;
  // Reset gates the write strobe so an aborted ST never reaches the RAM.
  assign RW = !((opcode == OP_ST) && Rst);

endmodule

// File: tb/tb_microprocesador.sv
// Self-checking bench for microprocesador: directed test-plan program, PC wrap,
// async reset during ST, then random instructions against an arithmetic reference model.
module tb_microprocesador;

  logic       Clk;
  logic       Rst;
  logic [7:0] Datos_Entrada;
  logic [8:0] Instrucciones;
  logic [7:0] Direccion_Instrucciones;
  logic [7:0] Direccion_Datos;
  logic [7:0] Salida_Datos;
  logic       RW;

  microprocesador dut (
    .Clk                     (Clk),
    .Rst                     (Rst),
    .Datos_Entrada           (Datos_Entrada),
    .Instrucciones           (Instrucciones),
    .Direccion_Instrucciones (Direccion_Instrucciones),
    .Direccion_Datos         (Direccion_Datos),
    .Salida_Datos            (Salida_Datos),
    .RW                      (RW)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference state, kept as plain integers.
  int m_pc, m_a, m_z, m_c;

  task automatic check(input string tag, input int observed, input int expected);
    n_total++;
    if (observed == expected) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic model_reset();
    m_pc = 0; m_a = 0; m_z = 0; m_c = 0;
  endtask

  // Architectural effect of one instruction, computed from the ISA rules.
  task automatic model_step(input int op, input int f, input int d);
    int sum;
    int next_pc;
    next_pc = (m_pc + 1) % 256;
    case (op)
      0: m_a = f;
      1: m_a = d;
      2: ;
      3: begin sum = m_a + d; m_c = (sum > 255) ? 1 : 0; m_a = sum % 256; end
      4: begin m_c = (m_a < d) ? 1 : 0; m_a = (m_a - d + 256) % 256; end
      5: m_a = m_a & d;
      6: next_pc = f;
      7: if (m_z == 1) next_pc = f;
      default: ;
    endcase
    if (op <= 5 && op != 2) m_z = (m_a == 0) ? 1 : 0;
    m_pc = next_pc;
  endtask

  // Present one instruction (called away from the rising edge), check the
  // combinational outputs, clock it in, then check the new architectural state.
  task automatic exec(input logic [8:0] instr, input logic [7:0] din, input bit full);
    int op, f;
    op = int'(instr[8:6]);
    f  = int'(instr[5:0]);
    Instrucciones = instr;
    Datos_Entrada = din;
    #1;
    if (full) begin
      check("daddr", int'(Direccion_Datos), f);
      check("wdata", int'(Salida_Datos), m_a);
      check("rw", int'(RW), (op == 2) ? 0 : 1);
    end
    model_step(op, f, int'(din));
    @(posedge Clk);
    #1;
    check("pc", int'(Direccion_Instrucciones), m_pc);
    if (full) begin
      check("acc", int'(Salida_Datos), m_a);
      check("z", int'(dut.z_q), m_z);
      check("c", int'(dut.c_q), m_c);
    end
  endtask

  initial begin
    logic [8:0] ins;
    Rst = 1'b0;
    Instrucciones = 9'b010_001000;
    Datos_Entrada = 8'h00;
    model_reset();
    #1;
    check("rst_pc", int'(Direccion_Instrucciones), 0);
    check("rst_acc", int'(Salida_Datos), 0);
    check("rst_rw", int'(RW), 1);
    check("rst_daddr", int'(Direccion_Datos), 8);
    @(negedge Clk);
    Rst = 1'b1;

    // Directed program following the test plan.
    exec(9'b000_101011, 8'h00, 1'b1);  // LDI 0x2B
    exec(9'b001_111011, 8'h0E, 1'b1);  // LD  -> 0x0E
    exec(9'b010_001000, 8'h00, 1'b1);  // ST  [0x08]
    exec(9'b011_111010, 8'h32, 1'b1);  // ADD -> 0x40
    exec(9'b000_001110, 8'h00, 1'b1);  // LDI 0x0E
    exec(9'b100_000000, 8'h0F, 1'b1);  // SUB -> 0xFF, borrow
    exec(9'b011_000000, 8'h01, 1'b1);  // ADD -> 0x00, C=1 Z=1
    exec(9'b111_101100, 8'h00, 1'b1);  // JZ taken -> 0x2C
    exec(9'b000_110010, 8'h00, 1'b1);  // LDI 0x32
    exec(9'b101_010000, 8'h0E, 1'b1);  // AND -> 0x02, C kept
    exec(9'b111_101100, 8'h00, 1'b1);  // JZ not taken
    exec(9'b000_110010, 8'h00, 1'b1);  // LDI 0x32
    exec(9'b101_010000, 8'hCD, 1'b1);  // AND -> 0x00
    exec(9'b110_011000, 8'h00, 1'b1);  // JMP 0x18

    // PC wrap: 256 non-jump instructions from reset.
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    model_reset();
    check("wrap_rst_pc", int'(Direccion_Instrucciones), 0);
    #1;
    Rst = 1'b1;
    for (int i = 0; i < 256; i++) begin
      ins = 9'($urandom_range(0, 383));
      exec(ins, 8'($urandom), 1'b0);
    end
    check("wrap_pc", int'(Direccion_Instrucciones), 0);

    // Async reset during a ST: RW must rise and PC clear without a clock edge.
    exec(9'b000_000101, 8'h00, 1'b1);
    Instrucciones = 9'b010_000011;
    #2;
    check("st_rw_before", int'(RW), 0);
    Rst = 1'b0;
    #1;
    model_reset();
    check("st_rst_rw", int'(RW), 1);
    check("st_rst_pc", int'(Direccion_Instrucciones), 0);
    check("st_rst_acc", int'(Salida_Datos), 0);
    #1;
    Rst = 1'b1;

    // Random programs; small data values bias toward zero results and borrows.
    for (int i = 0; i < 600; i++) begin
      ins = 9'($urandom);
      exec(ins, ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 2)) : 8'($urandom), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
